// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, stage occupancy states and the
// control-bundle field layout that decode and execute must slice identically.
package pipe_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } stage_state_e;

    localparam int unsigned CTRL_ALU_OP_LSB  = 0;
    localparam int unsigned CTRL_ALU_OP_W    = 5;
    localparam int unsigned CTRL_BJ_INST_LSB = 5;
    localparam int unsigned CTRL_BJ_INST_W   = 4;
    localparam int unsigned CTRL_WB_SEL_LSB  = 9;
    localparam int unsigned CTRL_WB_SEL_W    = 2;
    localparam int unsigned CTRL_WIDTH_LSB   = 11;
    localparam int unsigned CTRL_WIDTH_W     = 3;
    localparam int unsigned CTRL_EN_LSB      = 14;
    localparam int unsigned CTRL_EN_W        = 10;
    localparam int unsigned CTRL_BUNDLE_W    = CTRL_EN_LSB + CTRL_EN_W;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/id_ex_skid_stage.sv
// ID->EX pipeline stage with valid/ready handshake and a 2-entry skid buffer;
// supports hazard bubbles, branch flushes and saturating perf counters.
module id_ex_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned       CTRL_W   = 24,
    parameter int unsigned       DATA_W   = 160,
    parameter int unsigned       INSN_W   = 32,
    parameter logic [INSN_W-1:0] NOP_INSN = pipe_pkg::NOP_INSN,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [INSN_W-1:0] in_insn_i,
    input  logic              hazard_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [INSN_W-1:0] out_insn_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    stage_state_e      state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [INSN_W-1:0] main_insn_q, main_insn_d, skid_insn_q, skid_insn_d;
    logic              accept, fire;

    assign in_ready_o  = (state_q != StFull) & ~hazard_i & ~flush_i;
    assign out_valid_o = (state_q != StEmpty);
    assign accept      = in_valid_i & in_ready_o;
    assign fire        = out_valid_o & out_ready_i;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        main_insn_d = main_insn_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        skid_insn_d = skid_insn_q;
        // The head still fires this cycle; only what follows is killed.
        if (flush_i) begin
            state_d     = StEmpty;
            main_ctrl_d = '0;
            main_data_d = '0;
            main_insn_d = NOP_INSN;
            skid_ctrl_d = '0;
            skid_data_d = '0;
            skid_insn_d = NOP_INSN;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d     = StOne;
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                        main_insn_d = in_insn_i;
                    end
                end
                StOne: begin
                    if (accept && fire) begin
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                        main_insn_d = in_insn_i;
                    end else if (accept) begin
                        state_d     = StFull;
                        skid_ctrl_d = in_ctrl_i;
                        skid_data_d = in_data_i;
                        skid_insn_d = in_insn_i;
                    end else if (fire) begin
                        state_d     = StEmpty;
                        main_ctrl_d = '0;
                        main_data_d = '0;
                        main_insn_d = NOP_INSN;
                    end
                end
                StFull: begin
                    if (fire) begin
                        state_d     = StOne;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        main_insn_d = skid_insn_q;
                        skid_ctrl_d = '0;
                        skid_data_d = '0;
                        skid_insn_d = NOP_INSN;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            main_insn_q <= NOP_INSN;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_insn_q <= NOP_INSN;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            main_insn_q <= main_insn_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_insn_q <= skid_insn_d;
        end
    end

    assign out_ctrl_o = main_ctrl_q;
    assign out_data_o = main_data_q;
    assign out_insn_o = main_insn_q;

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_bubble_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (hazard_i & in_valid_i & ~flush_i),
        .count_o(bubble_cnt_o)
    );

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_flush_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (flush_i & (state_q != StEmpty)),
        .count_o(flush_cnt_o)
    );

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Self-checking bench for id_ex_skid_stage: directed vector table, reset and
// saturation sequences, then random traffic against a queue-based model.
module tb_id_ex_skid_stage;

    localparam int unsigned CTRL_W = 24;
    localparam int unsigned DATA_W = 160;
    localparam int unsigned INSN_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CNT_S  = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, in_valid, hazard, flush, out_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic [INSN_W-1:0] in_insn;
    logic              in_ready, out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [INSN_W-1:0] out_insn;
    logic [CNT_W-1:0]  bubble_cnt, flush_cnt;

    // Second instance with narrow counters so saturation is reachable quickly.
    logic              s_in_ready, s_out_valid;
    logic [CTRL_W-1:0] s_out_ctrl;
    logic [DATA_W-1:0] s_out_data;
    logic [INSN_W-1:0] s_out_insn;
    logic [CNT_S-1:0]  s_bubble_cnt, s_flush_cnt;

    id_ex_skid_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_ctrl_i(in_ctrl), .in_data_i(in_data), .in_insn_i(in_insn),
        .hazard_i(hazard), .flush_i(flush), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_ctrl_o(out_ctrl), .out_data_o(out_data),
        .out_insn_o(out_insn), .bubble_cnt_o(bubble_cnt), .flush_cnt_o(flush_cnt)
    );

    id_ex_skid_stage #(.CNT_W(CNT_S)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
        .in_ctrl_i(in_ctrl), .in_data_i(in_data), .in_insn_i(in_insn),
        .hazard_i(hazard), .flush_i(flush), .out_valid_o(s_out_valid),
        .out_ready_i(out_ready), .out_ctrl_o(s_out_ctrl), .out_data_o(s_out_data),
        .out_insn_o(s_out_insn), .bubble_cnt_o(s_bubble_cnt), .flush_cnt_o(s_flush_cnt)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [CTRL_W-1:0] ctrl_of(input logic [31:0] insn);
        return insn[23:0] ^ 24'h5A_C3A5;
    endfunction

    function automatic logic [DATA_W-1:0] data_of(input logic [31:0] insn);
        return {insn, ~insn, insn ^ 32'hDEAD_BEEF, insn + 32'd1, {insn[15:0], insn[31:16]}};
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ordered list of held instructions plus counters.
    logic [31:0] m_q[$];
    int          m_bub, m_fl, m_bub_s, m_fl_s;
    logic        m_acc;

    function automatic int sat_inc(input int v, input int max);
        return (v < max) ? v + 1 : v;
    endfunction

    function automatic logic m_ready();
        return (m_q.size() < 2) && !hazard && !flush;
    endfunction

    task automatic check_model();
        logic [31:0] hi;
        logic        v;
        v  = m_q.size() > 0;
        hi = v ? m_q[0] : NOP;
        chk("out_valid", DATA_W'(out_valid), DATA_W'(v));
        chk("out_insn", DATA_W'(out_insn), DATA_W'(hi));
        chk("out_ctrl", DATA_W'(out_ctrl), DATA_W'(v ? ctrl_of(hi) : '0));
        chk("out_data", out_data, v ? data_of(hi) : '0);
        chk("in_ready", DATA_W'(in_ready), DATA_W'(m_ready()));
        chk("bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(m_bub));
        chk("flush_cnt", DATA_W'(flush_cnt), DATA_W'(m_fl));
        chk("s_bubble_cnt", DATA_W'(s_bubble_cnt), DATA_W'(m_bub_s));
        chk("s_flush_cnt", DATA_W'(s_flush_cnt), DATA_W'(m_fl_s));
    endtask

    task automatic tick();
        logic acc, fire, iv, hz, fl;
        logic [31:0] ins;
        acc  = in_valid && m_ready();
        fire = (m_q.size() > 0) && out_ready;
        iv = in_valid; hz = hazard; fl = flush; ins = in_insn;
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_bub = 0; m_fl = 0; m_bub_s = 0; m_fl_s = 0;
            m_acc = 1'b0;
        end else begin
            if (hz && iv && !fl) begin
                m_bub   = sat_inc(m_bub, 65535);
                m_bub_s = sat_inc(m_bub_s, 15);
            end
            if (fl && m_q.size() > 0) begin
                m_fl   = sat_inc(m_fl, 65535);
                m_fl_s = sat_inc(m_fl_s, 15);
            end
            if (fire) void'(m_q.pop_front());
            if (fl) m_q.delete();
            else if (acc) m_q.push_back(ins);
            m_acc = acc;
        end
        #1;
    endtask

    task automatic drive(input logic iv, input logic hz, input logic fl, input logic ordy,
                         input logic [31:0] insn);
        in_valid = iv; hazard = hz; flush = fl; out_ready = ordy;
        in_insn = insn; in_ctrl = ctrl_of(insn); in_data = data_of(insn);
    endtask

    typedef struct {
        logic        iv, hz, fl, ordy;
        logic [31:0] insn;
        logic        ov;
        logic [31:0] einsn;
        logic        eir;
        int          ebub, efl;
    } vec_t;

    vec_t tbl[25];

    initial begin
        logic [31:0] a, b, c, d, e, f, g, h, i, j, k;
        a = 32'h0050_0093; b = 32'h0010_0113; c = 32'h0020_0193; d = 32'h0030_0213;
        e = 32'h0040_0293; f = 32'h0050_0313; g = 32'h0060_0393; h = 32'h0070_0413;
        i = 32'h0080_0493; j = 32'h0090_0513; k = 32'h00a0_0593;
        //            iv hz fl rdy insn | ov exp_insn ir bub fl
        tbl[0]  = '{1, 0, 0, 1, a,  0, NOP, 1, 0, 0};
        tbl[1]  = '{1, 0, 0, 1, b,  1, a,   1, 0, 0};
        tbl[2]  = '{1, 0, 0, 1, c,  1, b,   1, 0, 0};
        tbl[3]  = '{0, 0, 0, 1, 0,  1, c,   1, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0,  0, NOP, 1, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, d,  0, NOP, 1, 0, 0};
        tbl[6]  = '{1, 0, 0, 0, e,  1, d,   1, 0, 0};
        tbl[7]  = '{1, 0, 0, 0, f,  1, d,   0, 0, 0};
        tbl[8]  = '{1, 0, 0, 1, f,  1, d,   0, 0, 0};
        tbl[9]  = '{1, 0, 0, 1, f,  1, e,   1, 0, 0};
        tbl[10] = '{0, 0, 0, 1, 0,  1, f,   1, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0,  0, NOP, 1, 0, 0};
        tbl[12] = '{1, 0, 0, 0, g,  0, NOP, 1, 0, 0};
        tbl[13] = '{1, 0, 0, 0, h,  1, g,   1, 0, 0};
        tbl[14] = '{0, 0, 1, 1, 0,  1, g,   0, 0, 0};
        tbl[15] = '{0, 0, 0, 1, 0,  0, NOP, 1, 0, 1};
        tbl[16] = '{0, 0, 0, 1, 0,  0, NOP, 1, 0, 1};
        tbl[17] = '{1, 1, 0, 1, i,  0, NOP, 0, 0, 1};
        tbl[18] = '{1, 1, 0, 1, i,  0, NOP, 0, 1, 1};
        tbl[19] = '{1, 1, 0, 1, i,  0, NOP, 0, 2, 1};
        tbl[20] = '{1, 0, 0, 1, i,  0, NOP, 1, 3, 1};
        tbl[21] = '{0, 0, 0, 1, 0,  1, i,   1, 3, 1};
        tbl[22] = '{1, 0, 0, 0, j,  0, NOP, 1, 3, 1};
        tbl[23] = '{1, 1, 1, 0, k,  1, j,   0, 3, 1};
        tbl[24] = '{0, 0, 0, 0, 0,  0, NOP, 1, 3, 2};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int n = 0; n < 25; n++) begin
            drive(tbl[n].iv, tbl[n].hz, tbl[n].fl, tbl[n].ordy, tbl[n].insn);
            #1;
            check_model();
            chk($sformatf("vec%0d out_valid", n), DATA_W'(out_valid), DATA_W'(tbl[n].ov));
            chk($sformatf("vec%0d out_insn", n), DATA_W'(out_insn), DATA_W'(tbl[n].einsn));
            chk($sformatf("vec%0d in_ready", n), DATA_W'(in_ready), DATA_W'(tbl[n].eir));
            chk($sformatf("vec%0d bubble_cnt", n), DATA_W'(bubble_cnt), DATA_W'(tbl[n].ebub));
            chk($sformatf("vec%0d flush_cnt", n), DATA_W'(flush_cnt), DATA_W'(tbl[n].efl));
            tick();
        end

        // Reset while FULL discards both entries and clears counters.
        drive(1, 0, 0, 0, a); #1; tick();
        drive(1, 0, 0, 0, b); #1; tick();
        chk("full in_ready", DATA_W'(in_ready), DATA_W'(0));
        drive(1, 0, 0, 0, c);
        rst_n = 1'b0;
        #1; tick();
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 32'h0);
        #1;
        chk("rst out_valid", DATA_W'(out_valid), DATA_W'(0));
        chk("rst out_insn", DATA_W'(out_insn), DATA_W'(NOP));
        chk("rst out_ctrl", DATA_W'(out_ctrl), DATA_W'(0));
        chk("rst out_data", out_data, '0);
        chk("rst in_ready", DATA_W'(in_ready), DATA_W'(1));
        chk("rst bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(0));
        chk("rst flush_cnt", DATA_W'(flush_cnt), DATA_W'(0));
        check_model();
        tick();

        // Narrow counter: reach all-ones-minus-one, then 3 more hazard cycles.
        for (int n = 0; n < 14; n++) begin
            drive(1, 1, 0, 1, d); #1; check_model(); tick();
        end
        chk("sat pre s_bubble_cnt", DATA_W'(s_bubble_cnt), DATA_W'(4'hE));
        for (int n = 0; n < 3; n++) begin
            drive(1, 1, 0, 1, d); #1; check_model(); tick();
        end
        chk("sat s_bubble_cnt", DATA_W'(s_bubble_cnt), DATA_W'(4'hF));
        chk("sat bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(17));

        // Random traffic; upstream holds its offer until accepted or flushed.
        m_acc = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            logic hold;
            hold = in_valid && !m_acc && !flush;
            if (hold) begin
                hazard    = ($urandom_range(0, 4) == 0);
                flush     = ($urandom_range(0, 9) == 0);
                out_ready = ($urandom_range(0, 4) < 3);
            end else begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                      $urandom_range(0, 9) == 0, $urandom_range(0, 4) < 3, $urandom());
            end
            #1;
            check_model();
            tick();
        end
        drive(0, 0, 0, 1, 32'h0);
        #1;
        check_model();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
